// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback path.
package regfile_pkg;
  localparam int REG_AW   = 5;
  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;

  typedef logic [REG_AW-1:0] reg_idx_t;

  typedef struct packed {
    logic            valid;
    reg_idx_t        rd;
    logic [XLEN-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first request at or after i_ptr.
// The pointer register is owned by the parent.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_grant_idx,
  output logic               o_grant_valid
);

  int w_idx;

  always_comb begin
    o_grant       = '0;
    o_grant_idx   = '0;
    o_grant_valid = 1'b0;
    w_idx         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(i_ptr) + k) % NUM_REQ;
      if (!o_grant_valid && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = IDX_W'(w_idx);
        o_grant_valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter + pending-write scoreboard in front of the register file.
// Optional same-cycle forwarding of the committing write: REGFILE_WB_FORWARD_EN.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*REG_AW-1:0]  req_rd,
  input  logic [NUM_REQ*XLEN-1:0]    req_data,
  input  logic                       issue_valid,
  input  logic [REG_AW-1:0]          issue_rd,
  input  logic                       flush,
  input  logic [REG_AW-1:0]          rs1,
  input  logic [REG_AW-1:0]          rs2,
  output logic                       rs1_busy,
  output logic                       rs2_busy,
  output logic                       issue_rd_busy,
  output logic                       rf_we,
  output logic [REG_AW-1:0]          rf_rd,
  output logic [XLEN-1:0]            rf_wdata,
  output logic                       rs1_fwd_valid,
  output logic                       rs2_fwd_valid,
  output logic [XLEN-1:0]            rs1_fwd_data,
  output logic [XLEN-1:0]            rs2_fwd_data
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NREGS = 1 << REG_AW;

  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_grant_idx;
  logic               w_grant_valid;
  logic [REG_AW-1:0]  w_sel_rd;
  logic [XLEN-1:0]    w_sel_data;
  logic [NREGS-1:0]   w_pending_nxt;

  logic [IDX_W-1:0]   r_rr_ptr;
  logic [NREGS-1:0]   r_pending;
  logic               r_rf_we;
  logic [REG_AW-1:0]  r_rf_rd;
  logic [XLEN-1:0]    r_rf_wdata;

  // Handshake: a write transfers when req_valid[i] && req_ready[i]. The
  // requester keeps valid/rd/data stable until then; this side never stalls.
  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .i_req         (req_valid),
    .i_ptr         (r_rr_ptr),
    .o_grant       (w_grant),
    .o_grant_idx   (w_grant_idx),
    .o_grant_valid (w_grant_valid)
  );

  assign req_ready  = w_grant;
  assign w_sel_rd   = req_rd[w_grant_idx*REG_AW +: REG_AW];
  assign w_sel_data = req_data[w_grant_idx*XLEN +: XLEN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr   <= '0;
      r_rf_we    <= 1'b0;
      r_rf_rd    <= '0;
      r_rf_wdata <= '0;
      r_pending  <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_grant_valid) begin
        r_rr_ptr   <= (w_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
        // x0 writes are accepted but never reach the file
        r_rf_we    <= (w_sel_rd != '0);
        r_rf_rd    <= w_sel_rd;
        r_rf_wdata <= w_sel_data;
      end else begin
        r_rf_we <= 1'b0;
      end
    end
  end

  // Order matters: a new allocation overrides the commit clear, flush overrides all.
  always_comb begin
    w_pending_nxt = r_pending;
    if (r_rf_we) w_pending_nxt[r_rf_rd] = 1'b0;
    if (issue_valid && (issue_rd != '0)) w_pending_nxt[issue_rd] = 1'b1;
    if (flush) w_pending_nxt = '0;
    w_pending_nxt[0] = 1'b0;
  end

  assign rf_we         = r_rf_we;
  assign rf_rd         = r_rf_rd;
  assign rf_wdata      = r_rf_wdata;
  assign issue_rd_busy = r_pending[issue_rd];

`ifdef REGFILE_WB_FORWARD_EN
  assign rs1_fwd_valid = r_rf_we && (r_rf_rd == rs1) && (rs1 != '0);
  assign rs2_fwd_valid = r_rf_we && (r_rf_rd == rs2) && (rs2 != '0);
  assign rs1_fwd_data  = r_rf_wdata;
  assign rs2_fwd_data  = r_rf_wdata;
  assign rs1_busy      = r_pending[rs1] && !rs1_fwd_valid;
  assign rs2_busy      = r_pending[rs2] && !rs2_fwd_valid;
`else
  assign rs1_fwd_valid = 1'b0;
  assign rs2_fwd_valid = 1'b0;
  assign rs1_fwd_data  = '0;
  assign rs2_fwd_data  = '0;
  assign rs1_busy      = r_pending[rs1];
  assign rs2_busy      = r_pending[rs2];
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus a random run, all
// checked against a cycle model and an expected-output queue.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int NR = 2;
  localparam int EW = XLEN + REG_AW + 1;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NR-1:0]         req_valid;
  logic [NR-1:0]         req_ready;
  logic [NR*REG_AW-1:0]  req_rd;
  logic [NR*XLEN-1:0]    req_data;
  logic                  issue_valid;
  logic [REG_AW-1:0]     issue_rd;
  logic                  flush;
  logic [REG_AW-1:0]     rs1, rs2;
  logic                  rs1_busy, rs2_busy, issue_rd_busy;
  logic                  rf_we;
  logic [REG_AW-1:0]     rf_rd;
  logic [XLEN-1:0]       rf_wdata;
  logic                  rs1_fwd_valid, rs2_fwd_valid;
  logic [XLEN-1:0]       rs1_fwd_data, rs2_fwd_data;

  int errors = 0;
  int checks = 0;

  logic [EW-1:0]   exp_q[$];
  int              m_ptr;
  logic [31:0]     m_pend;
  logic            m_we;
  logic [REG_AW-1:0] m_rd;
  logic [XLEN-1:0] m_wd;
  logic [NR-1:0]   m_gnt;
  logic [XLEN-1:0] rf_mem [NUM_REGS];

  regfile_wb_arbiter #(.NUM_REQ(NR), .XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd), .req_data(req_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .issue_rd_busy(issue_rd_busy),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .rs1_fwd_valid(rs1_fwd_valid), .rs2_fwd_valid(rs2_fwd_valid),
    .rs1_fwd_data(rs1_fwd_data), .rs2_fwd_data(rs2_fwd_data)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(posedge clk) if (rf_we) rf_mem[rf_rd] <= rf_wdata;

  task automatic model_reset();
    m_ptr = 0; m_pend = '0; m_we = 1'b0; m_rd = '0; m_wd = '0; m_gnt = '0;
    exp_q.delete();
  endtask

  // driver tasks
  function automatic wb_req_t mk(input logic v, input logic [REG_AW-1:0] rd,
                                 input logic [XLEN-1:0] d);
    wb_req_t r;
    r.valid = v; r.rd = rd; r.data = d;
    return r;
  endfunction

  task automatic drive_req(input int i, input wb_req_t r);
    req_valid[i] = r.valid;
    req_rd[i*REG_AW +: REG_AW] = r.rd;
    req_data[i*XLEN +: XLEN] = r.data;
  endtask

  task automatic idle();
    req_valid = '0; req_rd = '0; req_data = '0;
    issue_valid = 1'b0; issue_rd = '0; flush = 1'b0; rs1 = '0; rs2 = '0;
  endtask

  task automatic fail_line(input string name, input logic [63:0] got, input logic [63:0] exp);
    errors++;
    $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // One clock: check combinational outputs against the model, push the
  // expected output-stage contents, clock, then pop and compare.
  task automatic step();
    int g;
    int j;
    logic [NR-1:0] exp_ready;
    logic [REG_AW-1:0] g_rd;
    logic [XLEN-1:0] g_data;
    logic [31:0] nxt;
    logic fwd1, fwd2;
    logic [EW-1:0] e;
    #1;
    g = -1; exp_ready = '0;
    for (int k = 0; k < NR; k++) begin
      j = (m_ptr + k) % NR;
      if (g < 0 && req_valid[j]) g = j;
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    checks++; if (req_ready !== exp_ready) fail_line("req_ready", 64'(req_ready), 64'(exp_ready));
`ifdef REGFILE_WB_FORWARD_EN
    fwd1 = m_we && (m_rd == rs1) && (rs1 != 0);
    fwd2 = m_we && (m_rd == rs2) && (rs2 != 0);
    if (fwd1) begin
      checks++; if (rs1_fwd_data !== m_wd) fail_line("rs1_fwd_data", 64'(rs1_fwd_data), 64'(m_wd));
    end
    if (fwd2) begin
      checks++; if (rs2_fwd_data !== m_wd) fail_line("rs2_fwd_data", 64'(rs2_fwd_data), 64'(m_wd));
    end
`else
    fwd1 = 1'b0; fwd2 = 1'b0;
    checks++; if (rs1_fwd_data !== '0) fail_line("rs1_fwd_data", 64'(rs1_fwd_data), 64'(0));
    checks++; if (rs2_fwd_data !== '0) fail_line("rs2_fwd_data", 64'(rs2_fwd_data), 64'(0));
`endif
    checks++; if (rs1_fwd_valid !== fwd1) fail_line("rs1_fwd_valid", 64'(rs1_fwd_valid), 64'(fwd1));
    checks++; if (rs2_fwd_valid !== fwd2) fail_line("rs2_fwd_valid", 64'(rs2_fwd_valid), 64'(fwd2));
    checks++; if (rs1_busy !== (m_pend[rs1] && !fwd1)) fail_line("rs1_busy", 64'(rs1_busy), 64'(m_pend[rs1] && !fwd1));
    checks++; if (rs2_busy !== (m_pend[rs2] && !fwd2)) fail_line("rs2_busy", 64'(rs2_busy), 64'(m_pend[rs2] && !fwd2));
    checks++; if (issue_rd_busy !== m_pend[issue_rd]) fail_line("issue_rd_busy", 64'(issue_rd_busy), 64'(m_pend[issue_rd]));
    nxt = m_pend;
    if (m_we) nxt[m_rd] = 1'b0;
    if (issue_valid && issue_rd != 0) nxt[issue_rd] = 1'b1;
    if (flush) nxt = '0;
    m_pend = nxt;
    m_gnt = exp_ready;
    if (g >= 0) begin
      g_rd = req_rd[g*REG_AW +: REG_AW];
      g_data = req_data[g*XLEN +: XLEN];
      m_ptr = (g + 1) % NR;
      m_we = (g_rd != 0); m_rd = g_rd; m_wd = g_data;
    end else begin
      m_we = 1'b0;
    end
    exp_q.push_back({m_we, m_rd, m_wd});
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if ({rf_we, rf_rd, rf_wdata} !== e) fail_line("rf_out{we,rd,data}", 64'({rf_we, rf_rd, rf_wdata}), 64'(e));
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    drive_req(0, mk(1'b1, 5'd1, 32'h11));
    drive_req(1, mk(1'b1, 5'd2, 32'h22));
    rs1 = 5'd1; rs2 = 5'd2; issue_rd = 5'd3;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rf_we !== 1'b0) fail_line("reset_rf_we", 64'(rf_we), 64'(0));
    checks++; if (rf_rd !== '0) fail_line("reset_rf_rd", 64'(rf_rd), 64'(0));
    checks++; if (rf_wdata !== '0) fail_line("reset_rf_wdata", 64'(rf_wdata), 64'(0));
    checks++; if ({rs1_busy, rs2_busy, issue_rd_busy, rs1_fwd_valid, rs2_fwd_valid} !== 5'b0)
      fail_line("reset_busy_fwd", 64'({rs1_busy, rs2_busy, issue_rd_busy, rs1_fwd_valid, rs2_fwd_valid}), 64'(0));
    checks++; if (req_ready !== 2'b01) fail_line("reset_ready", 64'(req_ready), 64'(2'b01));
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] exp_seq [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [REG_AW-1:0] rd_seq [4] = '{5'd1, 5'd2, 5'd1, 5'd2};
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (req_ready !== exp_seq[k]) fail_line("rr_grant", 64'(req_ready), 64'(exp_seq[k]));
      step();
      checks++; if (rf_rd !== rd_seq[k]) fail_line("rr_rf_rd", 64'(rf_rd), 64'(rd_seq[k]));
    end
    idle();
    step();
  endtask

  task automatic test_raw_clear();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd5; rs1 = 5'd5;
    step();
    issue_valid = 1'b0;
    step(); step();
    drive_req(1, mk(1'b1, 5'd5, 32'hDEADBEEF));
    #1;
    checks++; if (req_ready !== 2'b10) fail_line("raw_t3_ready", 64'(req_ready), 64'(2'b10));
    checks++; if (rs1_busy !== 1'b1) fail_line("raw_t3_busy", 64'(rs1_busy), 64'(1));
    step();
    drive_req(1, mk(1'b0, 5'd0, 32'h0));
    #1;
    checks++; if ({rf_we, rf_rd} !== {1'b1, 5'd5}) fail_line("raw_t4_commit", 64'({rf_we, rf_rd}), 64'({1'b1, 5'd5}));
`ifdef REGFILE_WB_FORWARD_EN
    checks++; if (rs1_busy !== 1'b0) fail_line("raw_t4_busy_fwd", 64'(rs1_busy), 64'(0));
`else
    checks++; if (rs1_busy !== 1'b1) fail_line("raw_t4_busy", 64'(rs1_busy), 64'(1));
`endif
    step();
    checks++; if (rs1_busy !== 1'b0) fail_line("raw_t5_busy", 64'(rs1_busy), 64'(0));
    checks++; if (rf_mem[5] !== 32'hDEADBEEF) fail_line("raw_t5_file", 64'(rf_mem[5]), 64'(32'hDEADBEEF));
  endtask

  task automatic test_same_cycle();
    idle();
    drive_req(0, mk(1'b1, 5'd7, 32'h77));
    step();
    drive_req(0, mk(1'b0, 5'd0, 32'h0));
    issue_valid = 1'b1; issue_rd = 5'd7;
    #1;
    checks++; if ({rf_we, rf_rd} !== {1'b1, 5'd7}) fail_line("same_commit", 64'({rf_we, rf_rd}), 64'({1'b1, 5'd7}));
    step();
    issue_valid = 1'b0; rs1 = 5'd7;
    #1;
    checks++; if (rs1_busy !== 1'b1) fail_line("same_set_wins", 64'(rs1_busy), 64'(1));
    drive_req(0, mk(1'b1, 5'd7, 32'h78));
    step();
    drive_req(0, mk(1'b0, 5'd0, 32'h0));
    step(); step();
  endtask

  task automatic test_rd_zero();
    idle();
    drive_req(0, mk(1'b1, 5'd0, 32'h1234));
    #1;
    checks++; if (req_ready !== 2'b01) fail_line("rd0_ready", 64'(req_ready), 64'(2'b01));
    checks++; if (rs1_busy !== 1'b0) fail_line("rd0_rs1_busy", 64'(rs1_busy), 64'(0));
    step();
    drive_req(0, mk(1'b0, 5'd0, 32'h0));
    checks++; if ({rf_we, rf_rd, rf_wdata} !== {1'b0, 5'd0, 32'h1234})
      fail_line("rd0_out", 64'({rf_we, rf_rd, rf_wdata}), 64'({1'b0, 5'd0, 32'h1234}));
    step();
  endtask

  task automatic test_flush();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd3; step();
    issue_rd = 5'd9; step();
    issue_valid = 1'b0;
    drive_req(1, mk(1'b1, 5'd3, 32'h3333));
    step();
    drive_req(1, mk(1'b0, 5'd0, 32'h0));
    flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd20; rs1 = 5'd3; rs2 = 5'd9;
    #1;
    checks++; if ({rf_we, rf_rd} !== {1'b1, 5'd3}) fail_line("flush_commit", 64'({rf_we, rf_rd}), 64'({1'b1, 5'd3}));
    step();
    flush = 1'b0; issue_valid = 1'b0;
    #1;
    checks++; if ({rs1_busy, rs2_busy, issue_rd_busy} !== 3'b000)
      fail_line("flush_busy", 64'({rs1_busy, rs2_busy, issue_rd_busy}), 64'(0));
    checks++; if (rf_mem[3] !== 32'h3333) fail_line("flush_file", 64'(rf_mem[3]), 64'(32'h3333));
    step();
  endtask

  task automatic test_forward();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd12; step();
    issue_valid = 1'b0;
    drive_req(0, mk(1'b1, 5'd12, 32'hA5A5A5A5));
    step();
    drive_req(0, mk(1'b0, 5'd0, 32'h0));
    rs2 = 5'd12;
    #1;
`ifdef REGFILE_WB_FORWARD_EN
    checks++; if (rs2_fwd_valid !== 1'b1) fail_line("fwd_valid", 64'(rs2_fwd_valid), 64'(1));
    checks++; if (rs2_fwd_data !== 32'hA5A5A5A5) fail_line("fwd_data", 64'(rs2_fwd_data), 64'(32'hA5A5A5A5));
    checks++; if (rs2_busy !== 1'b0) fail_line("fwd_busy", 64'(rs2_busy), 64'(0));
`else
    checks++; if (rs2_fwd_valid !== 1'b0) fail_line("nofwd_valid", 64'(rs2_fwd_valid), 64'(0));
    checks++; if (rs2_busy !== 1'b1) fail_line("nofwd_busy", 64'(rs2_busy), 64'(1));
`endif
    step(); step();
  endtask

  task automatic test_mid_reset();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd4; rs1 = 5'd4;
    drive_req(1, mk(1'b1, 5'd6, 32'h66));
    step();
    issue_valid = 1'b0;
    drive_req(0, mk(1'b1, 5'd8, 32'h88));
    drive_req(1, mk(1'b1, 5'd10, 32'hAA));
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({rf_we, rf_rd, rf_wdata} !== '0) fail_line("midrst_out", 64'({rf_we, rf_rd, rf_wdata}), 64'(0));
    checks++; if (rs1_busy !== 1'b0) fail_line("midrst_busy", 64'(rs1_busy), 64'(0));
    checks++; if (req_ready !== 2'b01) fail_line("midrst_ptr", 64'(req_ready), 64'(2'b01));
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    idle();
    step();
  endtask

  task automatic test_back_to_back();
    logic [REG_AW-1:0] r;
    idle();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] || m_gnt[i]) begin
          if ($urandom_range(0, 2) != 0)
            drive_req(i, mk(1'b1, REG_AW'($urandom_range(0, 31)), $urandom()));
          else
            drive_req(i, mk(1'b0, '0, '0));
        end
      end
      r = REG_AW'($urandom_range(0, 31));
      issue_rd = r;
      issue_valid = ($urandom_range(0, 1) == 0) && !m_pend[r];
      flush = ($urandom_range(0, 40) == 0);
      rs1 = REG_AW'($urandom_range(0, 31));
      rs2 = ($urandom_range(0, 1) == 0) ? m_rd : REG_AW'($urandom_range(0, 31));
      step();
    end
    idle();
    step();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_round_robin();
    test_raw_clear();
    test_same_cycle();
    test_rd_zero();
    test_flush();
    test_forward();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Writeback arbiter and scoreboard in front of the 32x32 RISC-V register file. The file has a single write port, and this block shares it between NUM_REQ writeback sources (e.g. ALU, load unit) using round-robin valid/ready arbitration. Winning writes go through one output register stage to the file. A per-register pending-write scoreboard gives the issue stage RAW/WAW hazard flags.

Parameters:
NUM_REQ, 2, number of writeback requesters (>=2)
XLEN, 32, data width
REG_AW, 5, register index width (32 registers)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  NUM_REQ  per-requester write request
req_ready  out  NUM_REQ  per-requester grant (combinational)
req_rd  in  NUM_REQ*REG_AW  flat destination indices; requester i at [i*REG_AW +: REG_AW]
req_data  in  NUM_REQ*XLEN  flat write data; requester i at [i*XLEN +: XLEN]
issue_valid  in  1  issue stage allocates a destination
issue_rd  in  REG_AW  destination being allocated
flush  in  1  clear the whole scoreboard
rs1, rs2  in  REG_AW each  source indices being checked
rs1_busy, rs2_busy  out  1 each  RAW hazard
issue_rd_busy  out  1  WAW hazard on issue_rd
rf_we  out  1  drives the register file reg_write
rf_rd  out  REG_AW  drives the register file rd
rf_wdata  out  XLEN  drives the register file write_data
rs1_fwd_valid, rs2_fwd_valid  out  1 each  forward hit (feature only)
rs1_fwd_data, rs2_fwd_data  out  XLEN each  forwarded data (feature only)

Behaviour:
- Reset values: rf_we=0, rf_rd=0, rf_wdata=0, pending=0, rr_ptr=0, all busy/fwd outputs 0. Reset is legal mid-operation; in-flight writes are dropped.
- Arbitration: combinational round-robin starting at rr_ptr. Exactly one req_ready is asserted for the first valid requester at or after rr_ptr, wrapping at NUM_REQ-1 -> 0. No valid requesters means req_ready=0.
- Handshake: a transfer happens when req_valid&req_ready. A requester holds valid/rd/data stable until accepted. The output always accepts one grant per cycle; there is no backpressure from the file.
- On grant i: rr_ptr <= (i+1) mod NUM_REQ. With no grant, rr_ptr is held.
- Output stage: the grant registers rd/data at the next edge, giving 1-cycle latency.
  - rf_we=1 that cycle unless rd==0. For rd==0 the write is accepted and discarded: rf_we=0, rf_rd/rf_wdata still updated.
  - The file writes at the end of the rf_we cycle.
- Scoreboard (pending[31:1]; bit 0 is constant 0):
  - set: issue_valid && issue_rd!=0 -> pending[issue_rd]<=1.
  - clear: rf_we -> pending[rf_rd]<=0, on the same edge the file commits.
  - set and clear on the same index in the same cycle: set wins (newer allocation).
  - flush: all pending<=0. An accepted write in the output stage still commits. A flush combined with issue_valid in the same cycle: flush wins.
- Hazards (combinational):
  - rs1_busy = pending[rs1]; likewise rs2_busy.
  - issue_rd_busy = pending[issue_rd].
  - Index 0 is never busy.
  - The issue stage must stall on issue_rd_busy; the scoreboard holds only one outstanding write per register.
- A requester writing a non-pending register is legal: it commits normally and the scoreboard is unchanged.

Optional Feature:
Macro: REGFILE_WB_FORWARD_EN.
- Defined:
  - rsN_fwd_valid = rf_we && rf_rd==rsN && rsN!=0, and rsN_fwd_data = rf_wdata.
  - rsN_busy is suppressed when rsN_fwd_valid. The consumer uses the forwarded data in the commit cycle.
- Undefined: fwd outputs tied to 0, and busy stays asserted through the commit cycle.

Decomposition:
- Package regfile_pkg:
  - REG_AW, XLEN, NUM_REGS=32 constants.
  - typedef reg_idx_t (logic [REG_AW-1:0]).
  - typedef wb_req_t struct {valid, rd, data}.
- Sub-module rr_arbiter (NUM_REQ): request vector plus pointer in, one-hot grant plus grant index out. Pure combinational; the pointer register stays in the parent.

Test Plan:
- Reset with req_valid=2'b11 held -> cycle 0 grants req0; then grants alternate req1, req0, req1 (rf_rd tracks the granted requester's rd).
- issue x5 at t0; req1 writes x5=0xDEADBEEF, granted t3 -> rs1=5 busy through t3 and through the t4 rf_we cycle; cleared from t5; file reads 0xDEADBEEF at t5.
- Same cycle: issue_rd=7 and rf_we with rf_rd=7 -> pending[7]=1 afterwards.
- Write rd=0 data 0x1234 -> req_ready=1, rf_we=0, no scoreboard change; rs1=0 never busy.
- Pending x3,x9 and output stage holding x3, then flush -> all busy=0 next cycle, x3 write still commits (rf_we=1).
- REGFILE_WB_FORWARD_EN: rf_we, rf_rd=12, rf_wdata=0xA5A5A5A5 with rs2=12 -> rs2_fwd_valid=1, rs2_fwd_data=0xA5A5A5A5, rs2_busy=0.
